multicycle_ctrl_fsm: RTL and testbench



---
 rtl/aardvark_ctrl_pkg.sv | 47 ++++
 rtl/ctrl_instr_class.sv | 25 ++
 rtl/multicycle_ctrl_fsm.sv | 139 +++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aardvark_ctrl_pkg.sv
// Shared encodings for the Aardvark main control unit and its ALU control decoder.
// Opcodes, ALU operation codes, FSM states, PC source selects and instruction classes.
package aardvark_ctrl_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_NAND  = 3'd1;
  localparam logic [2:0] OP_SLT   = 3'd2;
  localparam logic [2:0] OP_SHIFT = 3'd3;
  localparam logic [2:0] OP_ADDI  = 3'd4;
  localparam logic [2:0] OP_BEQ   = 3'd5;
  localparam logic [2:0] OP_JMP   = 3'd6;
  localparam logic [2:0] OP_MEM   = 3'd7;

  // The ALU control decoder consumes the opcode directly, so ALU ops share its values.
  localparam logic [2:0] ALUOP_ADD   = OP_ADD;
  localparam logic [2:0] ALUOP_NAND  = OP_NAND;
  localparam logic [2:0] ALUOP_SLT   = OP_SLT;
  localparam logic [2:0] ALUOP_SHIFT = OP_SHIFT;
  localparam logic [2:0] ALUOP_ADDI  = OP_ADDI;
  localparam logic [2:0] ALUOP_BEQ   = OP_BEQ;
  localparam logic [2:0] ALUOP_JMP   = OP_JMP;
  localparam logic [2:0] ALUOP_MEM   = OP_MEM;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_ADDI,
    CL_BEQ,
    CL_JMP,
    CL_LW,
    CL_SW,
    CL_NOP
  } iclass_e;

endpackage

// File: rtl/ctrl_instr_class.sv
// Classifies the latched opcode/funct pair into the instruction groups the
// control FSM sequences differently.
module ctrl_instr_class
  import aardvark_ctrl_pkg::*;
(
  input  logic [2:0] opcode_i,
  input  logic       funct_i,
  output iclass_e    iclass_o
);

  // add/nand with funct=0 and addi with funct=1 are unassigned encodings and retire as NOPs.
  always_comb begin
    iclass_o = CL_NOP;
    unique case (opcode_i)
      OP_ADD, OP_NAND: iclass_o = funct_i ? CL_RTYPE : CL_NOP;
      OP_SLT, OP_SHIFT: iclass_o = CL_RTYPE;
      OP_ADDI: iclass_o = funct_i ? CL_NOP : CL_ADDI;
      OP_BEQ: iclass_o = CL_BEQ;
      OP_JMP: iclass_o = CL_JMP;
      OP_MEM: iclass_o = funct_i ? CL_SW : CL_LW;
      default: iclass_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control for the 8-bit Aardvark CPU: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables and memory handshake.
module multicycle_ctrl_fsm
  import aardvark_ctrl_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [7:0]         instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               wb_sel_mem,
  output logic               alu_src_imm,
  output logic [2:0]         alu_op,
  output logic               funct,
  output logic               busy,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  state_e             state_q, state_d;
  logic [2:0]         opcode_q;
  logic               funct_q;
  logic [COUNT_W-1:0] count_q;
  logic               retire;
  iclass_e            iclass;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[4:1];

  ctrl_instr_class u_class (
    .opcode_i (opcode_q),
    .funct_i  (funct_q),
    .iclass_o (iclass)
  );

  // run is only consulted when an instruction retires, so a drop mid-instruction lets it finish.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (iclass == CL_JMP || iclass == CL_NOP) retire = 1'b1;
        else state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (iclass == CL_BEQ) retire = 1'b1;
        else if (iclass == CL_LW || iclass == CL_SW) state_d = ST_MEM;
        else state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (iclass == CL_SW) retire = 1'b1;
          else state_d = ST_WB;
        end
      end
      ST_WB:     retire = 1'b1;
      default:   state_d = ST_IDLE;
    endcase
    if (retire) state_d = run ? ST_FETCH : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= 3'd0;
      funct_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && mem_ready) begin
        opcode_q <= instr[7:5];
        funct_q  <= instr[0];
      end
      if (retire) count_q <= count_q + COUNT_W'(1);
    end
  end

  // Outputs decode from the state register, so an async reset clears them in the same cycle.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PCSRC_INC;
    reg_write   = 1'b0;
    wb_sel_mem  = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = (state_q == ST_IDLE) ? ALUOP_ADD : opcode_q;
    funct       = (state_q == ST_IDLE) ? 1'b0 : funct_q;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PCSRC_INC;
        end
      end
      ST_DECODE: begin
        if (iclass == CL_JMP) begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JMP;
        end
      end
      ST_EXEC: begin
        alu_src_imm = (iclass == CL_ADDI || iclass == CL_LW || iclass == CL_SW);
        if (iclass == CL_BEQ) begin
          pc_write = zero;
          pc_src   = PCSRC_BR;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = funct_q;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        wb_sel_mem = (opcode_q == OP_MEM);
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: each instruction's expected per-cycle
// output trace is queued up front, then drained one clock at a time against the DUT.
module tb_multicycle_ctrl_fsm;

  localparam int CW = 8;

  typedef struct packed {
    logic [2:0] st;
    logic       busy;
    logic       memReq;
    logic       memWe;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       regWrite;
    logic       wbSelMem;
    logic       aluSrcImm;
    logic [2:0] aluOp;
    logic       funct;
  } obs_t;

  typedef struct packed {
    logic memReady;
    logic run;
    obs_t exp;
  } step_t;

  logic          clk, rst_n, run, zero, mem_ready;
  logic [7:0]    instr;
  logic          mem_req, mem_we, ir_write, pc_write, reg_write, wb_sel_mem, alu_src_imm, funct, busy;
  logic [1:0]    pc_src;
  logic [2:0]    alu_op, state;
  logic [CW-1:0] instr_count;

  step_t         sbQ[$];
  int            totalChecks = 0;
  int            badChecks = 0;
  logic [2:0]    lastOp;
  logic          lastFunct;
  logic [CW-1:0] expCount;
  logic [7:0]    curIns;
  logic          curZero;
  string         curTag;

  multicycle_ctrl_fsm #(.COUNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .instr       (instr),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .wb_sel_mem  (wb_sel_mem),
    .alu_src_imm (alu_src_imm),
    .alu_op      (alu_op),
    .funct       (funct),
    .busy        (busy),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic obs_t sampleObs();
    obs_t o;
    o.st = state; o.busy = busy; o.memReq = mem_req; o.memWe = mem_we;
    o.irWrite = ir_write; o.pcWrite = pc_write; o.pcSrc = pc_src;
    o.regWrite = reg_write; o.wbSelMem = wb_sel_mem; o.aluSrcImm = alu_src_imm;
    o.aluOp = alu_op; o.funct = funct;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic pushStep(input logic mr, input logic rv, input obs_t e);
    step_t s;
    s.memReady = mr; s.run = rv; s.exp = e;
    sbQ.push_back(s);
  endtask

  task automatic pushIdle(input int n, input logic rv);
    obs_t e;
    e = '0;
    for (int i = 0; i < n; i++) pushStep(1'b0, rv, e);
  endtask

  // Expected trace for one instruction starting in FETCH.
  task automatic pushInstr(input string tag, input logic [7:0] ins, input logic zv,
                           input int fw, input int mw, input logic runEnd);
    obs_t e;
    logic [2:0] op;
    logic f, nop;
    op = ins[7:5];
    f = ins[0];
    nop = (op == 3'd0 && !f) || (op == 3'd1 && !f) || (op == 3'd4 && f);
    curTag = tag; curIns = ins; curZero = zv;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.st = 3'd1; e.busy = 1'b1; e.memReq = 1'b1;
      e.aluOp = lastOp; e.funct = lastFunct;
      if (i == fw) begin e.irWrite = 1'b1; e.pcWrite = 1'b1; e.pcSrc = 2'b00; end
      pushStep(i == fw, 1'b1, e);
    end
    lastOp = op; lastFunct = f;
    e = '0; e.st = 3'd2; e.busy = 1'b1; e.aluOp = op; e.funct = f;
    if (op == 3'd6) begin
      e.pcWrite = 1'b1; e.pcSrc = 2'b10;
      pushStep(1'b0, runEnd, e);
      return;
    end
    if (nop) begin
      pushStep(1'b0, runEnd, e);
      return;
    end
    pushStep(1'b0, 1'b1, e);
    e.st = 3'd3; e.aluSrcImm = (op == 3'd4 || op == 3'd7);
    if (op == 3'd5) begin
      e.pcWrite = zv; e.pcSrc = 2'b01;
      pushStep(1'b0, runEnd, e);
      return;
    end
    pushStep(1'b0, runEnd, e);
    e.aluSrcImm = 1'b0;
    if (op == 3'd7) begin
      for (int i = 0; i <= mw; i++) begin
        e.st = 3'd4; e.memReq = 1'b1; e.memWe = f;
        pushStep(i == mw, runEnd, e);
      end
      if (f) return;
      e.memReq = 1'b0; e.memWe = 1'b0;
    end
    e.st = 3'd5; e.regWrite = 1'b1; e.wbSelMem = (op == 3'd7);
    pushStep(1'b0, runEnd, e);
  endtask

  task automatic applyStimulus();
    step_t s;
    obs_t o;
    while (sbQ.size() > 0) begin
      s = sbQ.pop_front();
      @(negedge clk);
      mem_ready = s.memReady; run = s.run; instr = curIns; zero = curZero;
      #1;
      o = sampleObs();
      checkOutput(curTag, {15'd0, o}, {15'd0, s.exp});
    end
  endtask

  task automatic runInstr(input string tag, input logic [7:0] ins, input logic zv,
                          input int fw, input int mw, input logic runEnd);
    pushInstr(tag, ins, zv, fw, mw, runEnd);
    applyStimulus();
    expCount = expCount + CW'(1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_cnt"}, 32'(instr_count), 32'(expCount));
  endtask

  initial begin
    obs_t o;
    rst_n = 1'b0; run = 1'b0; instr = 8'h00; zero = 1'b0; mem_ready = 1'b0;
    lastOp = 3'd0; lastFunct = 1'b0; expCount = '0; curIns = 8'h00; curZero = 1'b0; curTag = "idle";
    @(negedge clk);
    #1;
    o = sampleObs();
    checkOutput("rst_outs", {15'd0, o}, 32'd0);
    checkOutput("rst_cnt", 32'(instr_count), 32'd0);
    rst_n = 1'b1;

    pushIdle(2, 1'b0);
    pushIdle(1, 1'b1);
    applyStimulus();

    runInstr("add",   8'b000_0000_1, 1'b0, 0, 0, 1'b1);
    runInstr("lw",    8'b111_0110_0, 1'b0, 0, 3, 1'b1);
    runInstr("sw",    8'b111_1001_1, 1'b0, 2, 0, 1'b1);
    runInstr("beq1",  8'b101_1010_1, 1'b1, 0, 0, 1'b1);
    runInstr("beq0",  8'b101_0101_0, 1'b0, 0, 0, 1'b1);
    runInstr("j",     8'b110_0011_1, 1'b0, 1, 0, 1'b1);
    runInstr("nop0",  8'b000_1111_0, 1'b0, 0, 0, 1'b1);
    runInstr("nop1",  8'b001_0000_0, 1'b0, 0, 0, 1'b1);
    runInstr("nop4",  8'b100_0000_1, 1'b0, 0, 0, 1'b1);
    runInstr("nand",  8'b001_0000_1, 1'b0, 0, 0, 1'b1);
    runInstr("slt",   8'b010_1100_0, 1'b0, 0, 0, 1'b1);
    runInstr("shl",   8'b011_0000_0, 1'b0, 0, 0, 1'b1);
    runInstr("shr",   8'b011_0000_1, 1'b0, 0, 0, 1'b1);
    runInstr("addi",  8'b100_0110_0, 1'b0, 0, 0, 1'b1);

    // Async reset while lw is stalled in MEM.
    pushInstr("lwrst", 8'b111_0000_0, 1'b0, 0, 1, 1'b1);
    void'(sbQ.pop_back());
    void'(sbQ.pop_back());
    applyStimulus();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checkOutput("pre_rst_memreq", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    o = sampleObs();
    checkOutput("midrst_outs", {15'd0, o}, 32'd0);
    checkOutput("midrst_cnt", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_state", 32'(state), 32'd1);
    lastOp = 3'd0; lastFunct = 1'b0; expCount = '0;

    // Drop run during EXEC: add completes, then the FSM parks in IDLE.
    runInstr("add_stop", 8'b000_1010_1, 1'b0, 0, 0, 1'b0);
    pushIdle(2, 1'b0);
    pushIdle(1, 1'b1);
    curTag = "idle_after_stop";
    applyStimulus();

    // Counter wrap at all-ones.
    while (expCount != {CW{1'b1}}) runInstr("nopw", 8'b000_0000_0, 1'b0, 0, 0, 1'b1);
    runInstr("nop_wrap", 8'b001_0000_0, 1'b0, 0, 0, 1'b1);
    checkOutput("wrap_zero", 32'(instr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
